// File: rtl/swgate_pkg.sv
// Shared definitions for the switch gate array.
//   mode_e    : display mode, advanced by the mode button (LIVE -> INVERT -> HOLD -> LIVE)
//   LED_*     : bit positions of each gate result on the LED bus
//   next_mode : successor of a mode; the unused encoding 3 falls back to LIVE
package swgate_pkg;

  typedef enum logic [1:0] {
    MODE_LIVE   = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_HOLD   = 2'd2
  } mode_e;

  localparam int LED_W    = 4;
  localparam int LED_AND  = 0;
  localparam int LED_OR   = 1;
  localparam int LED_NAND = 2;
  localparam int LED_XOR  = 3;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_LIVE:   return MODE_INVERT;
      MODE_INVERT: return MODE_HOLD;
      default:     return MODE_LIVE;
    endcase
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Debounce filter for one raw asynchronous input.
// A 2-flop synchroniser feeds a saturating counter. The counter runs while the
// synchronised level differs from the accepted "stable" level. It is cleared
// whenever the two agree, so any glitch that ends early leaves no trace.
// The stable bit flips on the edge where the counter already holds
// DEBOUNCE_CYCLES-1, i.e. after DEBOUNCE_CYCLES consecutive differing samples.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   raw        : raw asynchronous level
//   stable     : debounced level (registered)
//   rise       : combinational strobe, high in the cycle before stable goes 0 -> 1,
//                so a consumer can act on the same edge that updates stable
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          stable_q;
  logic          flip;

  // sync_q[1] is the synchronised level; sync_q[0] is the metastability flop.
  assign flip   = (sync_q[1] != stable_q) && (cnt_q == LAST);
  assign stable = stable_q;
  assign rise   = flip & sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (flip) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_gate_array.sv
// Switch gate array: debounces NUM_SW switches and a mode button, computes
// AND / OR / NAND / XOR over the debounced switches and shows them on o_LED
// according to the current mode (LIVE, INVERT or HOLD).
// Ports:
//   i_Clk      : system clock, rising edge
//   i_Rst_n    : synchronous active-low reset
//   i_Switch   : raw switch levels, bit k = switch k
//   i_Mode_Btn : raw mode button, high = pressed
//   o_LED      : registered results [0] AND, [1] OR, [2] NAND, [3] XOR
//   o_Mode     : current mode (0 LIVE, 1 INVERT, 2 HOLD); this is the FSM state
module switch_gate_array
  import swgate_pkg::*;
#(
  parameter int NUM_SW          = 2,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [NUM_SW-1:0] i_Switch,
  input  logic              i_Mode_Btn,
  output logic [LED_W-1:0]  o_LED,
  output logic [1:0]        o_Mode
);

  logic [NUM_SW-1:0] sw_stable;
  logic [NUM_SW-1:0] unused_sw_rise;     // switches are used as levels only
  logic              btn_rise;
  logic              unused_btn_stable;  // the button is used as an edge only

  for (genvar k = 0; k < NUM_SW; k++) begin : g_sw
    debounce_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filt (
      .clk    (i_Clk),
      .rst_n  (i_Rst_n),
      .raw    (i_Switch[k]),
      .stable (sw_stable[k]),
      .rise   (unused_sw_rise[k])
    );
  end

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (i_Clk),
    .rst_n  (i_Rst_n),
    .raw    (i_Mode_Btn),
    .stable (unused_btn_stable),
    .rise   (btn_rise)
  );

  logic [LED_W-1:0] gates;

  always_comb begin
    gates           = '0;
    gates[LED_AND]  = &sw_stable;
    gates[LED_OR]   = |sw_stable;
    gates[LED_NAND] = ~(&sw_stable);
    gates[LED_XOR]  = ^sw_stable;
  end

  mode_e mode_q;
  logic  run_q;

  // The mode advances on the same edge the debounced button rises, which is
  // the same edge a debounced switch change lands; o_LED picks up both on the
  // following edge. run_q holds o_LED at zero for the first edge after reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      mode_q <= MODE_LIVE;
      run_q  <= 1'b0;
      o_LED  <= '0;
    end else begin
      run_q <= 1'b1;
      if (btn_rise) begin
        mode_q <= next_mode(mode_q);
      end
      if (run_q) begin
        case (mode_q)
          MODE_LIVE:   o_LED <= gates;
          MODE_INVERT: o_LED <= ~gates;
          default:     o_LED <= o_LED;
        endcase
      end
    end
  end

  assign o_Mode = mode_q;

endmodule
